cell_draw_sequencer: RTL and testbench

CELL_DRAW_SEQUENCER -- requirements
Module: cell_draw_sequencer

---
 rtl/cell_draw_sequencer.sv | 140 ++++++++++++++
 tb/tb_cell_draw_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_draw_sequencer.sv
// ---------------------------------------------------------------------------
// cell_draw_sequencer
//
// Purpose: repaints cells of a 7x6 game board on a 160x120 VGA adapter.
//   A scan pointer walks the 42 cells one per cycle. A cell is repainted when
//   its board value differs from the last value drawn (shadow copy) or when
//   its dirty bit is set. A repaint streams an 8x8 sprite: 64 ROM addresses,
//   each followed one cycle later by a pixel plot.
//
// Ports:
//   CLOCK_50    in   sole clock, rising edge
//   Reset       in   synchronous, active-high reset
//   board_flat  in   84  cell i at [2i+1:2i]; 00 empty, 01 P1, 10 P2
//   redraw_all  in   one-cycle request to repaint every cell
//   mem_addr    out  6   sprite ROM address {yc, xc}; 0 outside a draw
//   sprite_sel  out  2   value of the cell being drawn (ROM select)
//   plot        out  pixel write strobe
//   vga_x       out  8   pixel x
//   vga_y       out  7   pixel y
//   busy        out  high during a draw and its trailing plot cycle
//   draw_done   out  pulse on the last plot cycle of a cell
//
// Configuration:
//   CELL_DRAW_REDRAW_ALL_EN  when defined, redraw_all sets every dirty bit;
//                            otherwise redraw_all is ignored.
// ---------------------------------------------------------------------------
module cell_draw_sequencer (
    input  logic        CLOCK_50,
    input  logic        Reset,
    input  logic [83:0] board_flat,
    input  logic        redraw_all,
    output logic [5:0]  mem_addr,
    output logic [1:0]  sprite_sel,
    output logic        plot,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic        busy,
    output logic        draw_done
);

    localparam logic       S_SCAN    = 1'b0;
    localparam logic       S_DRAW    = 1'b1;
    localparam logic [5:0] LAST_CELL = 6'd41;
    localparam logic [5:0] LAST_PIX  = 6'd63;

    logic        state;
    // ptr doubles as the latched cell index: it is frozen for the whole draw.
    logic [5:0]  ptr;
    logic [83:0] shadow;
    logic [41:0] dirty;
    logic [41:0] dirty_next;
    logic [5:0]  cnt;
    logic [7:0]  x0;
    logic [6:0]  y0;

    logic [1:0]  cur_val;
    logic [1:0]  shadow_val;
    logic        candidate;
    logic [5:0]  ptr_next;
    logic [2:0]  row;
    logic [2:0]  col;

    assign cur_val    = board_flat[{ptr, 1'b0} +: 2];
    assign shadow_val = shadow[{ptr, 1'b0} +: 2];
    assign candidate  = (state == S_SCAN) && ((cur_val != shadow_val) || dirty[ptr]);
    assign ptr_next   = (ptr == LAST_CELL) ? 6'd0 : ptr + 6'd1;
    assign row        = 3'(ptr / 6'd7);
    assign col        = 3'(ptr % 6'd7);

    assign mem_addr   = (state == S_DRAW) ? cnt : 6'd0;
    // draw_done marks the trailing plot cycle, which already sits in SCAN.
    assign busy       = (state == S_DRAW) | draw_done;

    always_comb begin
        dirty_next = dirty;
        if (candidate)
            dirty_next[ptr] = 1'b0;
`ifdef CELL_DRAW_REDRAW_ALL_EN
        // A redraw request issued on a latch cycle keeps that cell dirty.
        if (redraw_all)
            dirty_next = '1;
`endif
    end

`ifndef CELL_DRAW_REDRAW_ALL_EN
    logic unused_redraw;
    assign unused_redraw = redraw_all;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state      <= S_SCAN;
            ptr        <= 6'd0;
            shadow     <= '0;
            dirty      <= '0;
            cnt        <= 6'd0;
            x0         <= 8'd0;
            y0         <= 7'd0;
            sprite_sel <= 2'b00;
            plot       <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            draw_done  <= 1'b0;
        end else begin
            dirty <= dirty_next;

            // Pixel stage: follows the ROM address by one cycle to match the
            // registered sprite ROM.
            plot      <= (state == S_DRAW);
            draw_done <= (state == S_DRAW) && (cnt == LAST_PIX);
            if (state == S_DRAW) begin
                vga_x <= x0 + {5'b0, cnt[2:0]};
                vga_y <= y0 + {4'b0, cnt[5:3]};
            end

            case (state)
                S_SCAN: begin
                    if (candidate) begin
                        state                       <= S_DRAW;
                        sprite_sel                  <= cur_val;
                        shadow[{ptr, 1'b0} +: 2]    <= cur_val;
                        x0                          <= 8'd37 + 8'd13 * {5'b0, col};
                        y0                          <= 7'd24 + 7'd13 * {4'b0, row};
                        cnt                         <= 6'd0;
                    end else begin
                        ptr <= ptr_next;
                    end
                end
                default: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST_PIX) begin
                        state <= S_SCAN;
                        ptr   <= ptr_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell_draw_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cell_draw_sequencer
//
// Self-checking bench. A timeline model (cycle of the last latch, latched
// cell, scan pointer, shadow/dirty arrays) predicts every output on every
// cycle; directed scenarios add literal expectations for coordinates, draw
// order, gaps and plot counts; a random phase exercises board churn.
// ---------------------------------------------------------------------------
module tb_cell_draw_sequencer;

    logic        CLOCK_50;
    logic        Reset;
    logic [83:0] board_flat;
    logic        redraw_all;
    logic [5:0]  mem_addr;
    logic [1:0]  sprite_sel;
    logic        plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic        busy;
    logic        draw_done;

    cell_draw_sequencer dut (
        .CLOCK_50   (CLOCK_50),
        .Reset      (Reset),
        .board_flat (board_flat),
        .redraw_all (redraw_all),
        .mem_addr   (mem_addr),
        .sprite_sel (sprite_sel),
        .plot       (plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .busy       (busy),
        .draw_done  (draw_done)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint   cyc     = 0;
    bit       chk_en  = 0;
    int       m_ptr;
    bit [1:0] m_shadow [42];
    bit       m_dirty  [42];
    longint   lat     = -1000;
    int       lat_idx = 0;
    int       lat_val = 0;
    int       ex_x    = 0;
    int       ex_y    = 0;

    always @(posedge CLOCK_50) begin
        if (Reset) begin
            m_ptr = 0;
            for (int i = 0; i < 42; i++) begin
                m_shadow[i] = 2'b00;
                m_dirty[i]  = 1'b0;
            end
            lat     = -1000;
            lat_idx = 0;
            lat_val = 0;
            ex_x    = 0;
            ex_y    = 0;
            chk_en  = 1;
        end else begin
            if (cyc >= lat + 1 && cyc <= lat + 64) begin
                if (cyc == lat + 64)
                    m_ptr = (lat_idx + 1) % 42;
            end else begin
                bit [1:0] v;
                v = board_flat[2*m_ptr +: 2];
                if (v != m_shadow[m_ptr] || m_dirty[m_ptr]) begin
                    lat     = cyc;
                    lat_idx = m_ptr;
                    lat_val = v;
                    m_shadow[m_ptr] = v;
                    m_dirty[m_ptr]  = 1'b0;
                end else begin
                    m_ptr = (m_ptr + 1) % 42;
                end
            end
`ifdef CELL_DRAW_REDRAW_ALL_EN
            if (redraw_all)
                for (int i = 0; i < 42; i++) m_dirty[i] = 1'b1;
`endif
        end
        cyc++;
    end

    // ---------------- compare + monitor ----------------
    int     plot_total   = 0;
    int     plot_in_draw = 0;
    bit     prev_plot    = 0;
    int     q_fx[$], q_fy[$], q_lx[$], q_ly[$], q_sel[$], q_cnt[$];
    longint q_start[$], q_done[$];

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            bit in_draw, e_plot;
            longint a;
            in_draw = (cyc >= lat + 1) && (cyc <= lat + 64);
            e_plot  = (cyc >= lat + 2) && (cyc <= lat + 65);
            if (e_plot) begin
                a    = cyc - lat - 2;
                ex_x = 37 + 13 * (lat_idx % 7) + int'(a % 8);
                ex_y = 24 + 13 * (lat_idx / 7) + int'(a / 8);
            end
            chk("mem_addr",   mem_addr,   in_draw ? cyc - lat - 1 : 0);
            chk("plot",       plot,       e_plot);
            chk("vga_x",      vga_x,      ex_x);
            chk("vga_y",      vga_y,      ex_y);
            chk("sprite_sel", sprite_sel, lat_val);
            chk("busy",       busy,       (cyc >= lat + 1) && (cyc <= lat + 65));
            chk("draw_done",  draw_done,  cyc == lat + 65);
        end
        if (plot && !prev_plot) begin
            plot_in_draw = 0;
            q_fx.push_back(vga_x);
            q_fy.push_back(vga_y);
            q_start.push_back(cyc);
        end
        if (plot) begin
            plot_in_draw++;
            plot_total++;
        end
        if (draw_done) begin
            q_lx.push_back(vga_x);
            q_ly.push_back(vga_y);
            q_sel.push_back(sprite_sel);
            q_done.push_back(cyc);
            q_cnt.push_back(plot_in_draw);
        end
        prev_plot = plot;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic clear_logs();
        plot_total = 0;
        q_fx.delete(); q_fy.delete(); q_lx.delete(); q_ly.delete();
        q_sel.delete(); q_cnt.delete(); q_start.delete(); q_done.delete();
    endtask

    task automatic reset_board(input logic [83:0] b);
        Reset      = 1'b1;
        board_flat = b;
        tick();
        tick();
        Reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_dones(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (q_done.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(nm, q_done.size() >= n, 1);
    endtask

    task automatic wait_plot(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (!(plot && plot_in_draw == n) && k < budget) begin
            tick();
            k++;
        end
        chk(nm, plot && plot_in_draw == n, 1);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [83:0] b;
        Reset      = 1'b1;
        board_flat = '0;
        redraw_all = 1'b0;
        repeat (3) tick();

        // reset values
        chk("rst_plot",  plot, 0);
        chk("rst_addr",  mem_addr, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  draw_done, 0);
        chk("rst_x",     vga_x, 0);
        chk("rst_y",     vga_y, 0);
        chk("rst_sel",   sprite_sel, 0);
        Reset = 1'b0;
        clear_logs();

        // empty board stays idle
        repeat (200) tick();
        chk("idle_plots", plot_total, 0);

        // cell 0 -> P2
        clear_logs();
        board_flat[1:0] = 2'b10;
        wait_dones(1, 300, "c0_wait");
        if (q_done.size() >= 1) begin
            chk("c0_first_x", q_fx[0], 37);
            chk("c0_first_y", q_fy[0], 24);
            chk("c0_last_x",  q_lx[0], 44);
            chk("c0_last_y",  q_ly[0], 31);
            chk("c0_sel",     q_sel[0], 2);
            chk("c0_nplots",  q_cnt[0], 64);
        end

        // cells 41 and 3 together with ptr at 0: cell 3 first
        b = '0;
        b[83:82] = 2'b01;
        b[7:6]   = 2'b10;
        reset_board(b);
        wait_dones(2, 400, "c3_41_wait");
        if (q_done.size() >= 2) begin
            chk("c3_first_x",  q_fx[0], 76);
            chk("c3_first_y",  q_fy[0], 24);
            chk("c3_sel",      q_sel[0], 2);
            chk("c41_first_x", q_fx[1], 115);
            chk("c41_first_y", q_fy[1], 89);
            chk("c41_last_x",  q_lx[1], 122);
            chk("c41_last_y",  q_ly[1], 96);
            chk("c41_sel",     q_sel[1], 1);
            chk("c3_c41_gap",  q_start[1] - q_done[0], 39);
        end

        // change a cell during its own draw
        reset_board('0);
        board_flat[1:0] = 2'b01;
        wait_plot(1, 100, "chg_start");
        board_flat[1:0] = 2'b10;
        wait_dones(2, 400, "chg_wait");
        if (q_done.size() >= 2) begin
            chk("chg_sel0",  q_sel[0], 1);
            chk("chg_sel1",  q_sel[1], 2);
            chk("chg_cnt0",  q_cnt[0], 64);
            chk("chg_cnt1",  q_cnt[1], 64);
        end

        // reset on the 30th plot cycle
        reset_board('0);
        board_flat[9:8] = 2'b01;
        wait_plot(30, 200, "abort_wait");
        Reset = 1'b1;
        tick();
        chk("abort_plot", plot, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", draw_done, 0);
        chk("abort_x",    vga_x, 0);
        chk("abort_y",    vga_y, 0);
        chk("abort_sel",  sprite_sel, 0);
        tick();
        Reset = 1'b0;

        // random board churn
        for (int i = 0; i < 2000; i++) begin
            tick();
            if ($urandom_range(15) == 0) begin
                int c;
                c = $urandom_range(41);
                board_flat[2*c +: 2] = 2'($urandom_range(2));
            end
            redraw_all = ($urandom_range(299) == 0);
        end
        redraw_all = 1'b0;
        repeat (3200) tick();

        // redraw_all on a static board
        clear_logs();
        repeat (200) tick();
        chk("static_idle", plot_total, 0);
        redraw_all = 1'b1;
        tick();
        redraw_all = 1'b0;
        repeat (3000) tick();
`ifdef CELL_DRAW_REDRAW_ALL_EN
        chk("redraw_plots", plot_total, 2688);
        chk("redraw_draws", q_done.size(), 42);
`else
        chk("redraw_plots", plot_total, 0);
`endif
        clear_logs();
        repeat (200) tick();
        chk("post_idle", plot_total, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
